control_fsm: RTL

//  Multi-cycle control sequencer for the LEGv8-style CPU datapath. Decodes

---
 rtl/ctrl_pkg.sv | 43 ++++
 rtl/ctrl_decode.sv | 48 ++++
 rtl/control_fsm.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and constants for the LEGv8 multi-cycle control
// sequencer (control_fsm) and its opcode decoder (ctrl_decode).
//   state_t        : sequencer states
//   instr_class_t  : decoded instruction class
//   OPC_* / ALU_*  : opcode match values and op_alu encodings
package ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    TRAP
  } state_t;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_LD,
    CLS_ST,
    CLS_CBZ,
    CLS_B,
    CLS_ILL
  } instr_class_t;

  // Full 11-bit opcodes
  localparam logic [10:0] OPC_ADD  = 11'h458;
  localparam logic [10:0] OPC_SUB  = 11'h658;
  localparam logic [10:0] OPC_AND  = 11'h450;
  localparam logic [10:0] OPC_ORR  = 11'h550;
  localparam logic [10:0] OPC_LDUR = 11'h7C2;
  localparam logic [10:0] OPC_STUR = 11'h7C0;
  // Prefix-matched opcodes: CBZ on opcode[10:3], B on opcode[10:5]
  localparam logic [7:0]  OPC_CBZ  = 8'hB4;
  localparam logic [5:0]  OPC_B    = 6'h05;

  localparam logic [2:0] ALU_AND   = 3'b000;
  localparam logic [2:0] ALU_ORR   = 3'b001;
  localparam logic [2:0] ALU_ADD   = 3'b010;
  localparam logic [2:0] ALU_SUB   = 3'b110;
  localparam logic [2:0] ALU_PASSB = 3'b111;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode decoder.
//   opcode     in  11  instruction[31:21]
//   instrClass out 3   instr_class_t encoding of the instruction class
//   aluOp      out 3   ALU operation the instruction uses in EXEC..WB
//                      (ADD for address generation, PASS_B for CBZ)
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [10:0] opcode,
  output logic [2:0]  instrClass,
  output logic [2:0]  aluOp
);

  instr_class_t cls;

  always_comb begin
    cls   = CLS_ILL;
    aluOp = ALU_AND;
    if (opcode == OPC_ADD) begin
      cls   = CLS_R;
      aluOp = ALU_ADD;
    end else if (opcode == OPC_SUB) begin
      cls   = CLS_R;
      aluOp = ALU_SUB;
    end else if (opcode == OPC_AND) begin
      cls   = CLS_R;
      aluOp = ALU_AND;
    end else if (opcode == OPC_ORR) begin
      cls   = CLS_R;
      aluOp = ALU_ORR;
    end else if (opcode == OPC_LDUR) begin
      cls   = CLS_LD;
      aluOp = ALU_ADD;
    end else if (opcode == OPC_STUR) begin
      cls   = CLS_ST;
      aluOp = ALU_ADD;
    end else if (opcode[10:3] == OPC_CBZ) begin
      cls   = CLS_CBZ;
      aluOp = ALU_PASSB;
    end else if (opcode[10:5] == OPC_B) begin
      cls   = CLS_B;
      aluOp = ALU_AND;
    end
  end

  assign instrClass = cls;

endmodule

// File: rtl/control_fsm.sv
// control_fsm: multi-cycle control sequencer for the LEGv8-style datapath.
// Steps FETCH/DECODE/EXEC/MEM/WB and drives all datapath control lines.
// Optional feature macro: CTRL_PERF_CNT_EN adds cyc_cnt/ret_cnt counters.
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   run                  1 = sequence, 0 = hold in FETCH between instructions
//   opcode               instruction[31:21]
//   zero                 ALU Z flag (CBZ condition)
//   imem_ready/dmem_ready memory handshakes
//   ir_load, w_pc, reg_mux_sel, w_regbank, alu_mux_sel, op_alu,
//   jump_mux_sel, read_mem, write_mem, mem_sel   datapath controls
//   illegal              sticky undefined-opcode flag (TRAP state)
//   cyc_cnt, ret_cnt     perf counters (CTRL_PERF_CNT_EN only)
module control_fsm
  import ctrl_pkg::*;
#(
  parameter int OPW = 3
`ifdef CTRL_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           run,
  input  logic [10:0]    opcode,
  input  logic           zero,
  input  logic           imem_ready,
  input  logic           dmem_ready,
  output logic           ir_load,
  output logic           w_pc,
  output logic           reg_mux_sel,
  output logic           w_regbank,
  output logic           alu_mux_sel,
  output logic [OPW-1:0] op_alu,
  output logic           jump_mux_sel,
  output logic           read_mem,
  output logic           write_mem,
  output logic           mem_sel,
  output logic           illegal
`ifdef CTRL_PERF_CNT_EN
  , output logic [CNT_W-1:0] cyc_cnt
  , output logic [CNT_W-1:0] ret_cnt
`endif
);

  state_t       state, nextState;
  instr_class_t cls;
  logic [10:0]  irOp;
  logic [2:0]   clsRaw, aluOpDec, aluOp;
  logic         irLoadRaw, regMuxCls;

  // Own copy of the opcode: the imem output may change once the fetch is
  // done, and the mux/op outputs must stay stable through MEM/WB.
  ctrl_decode uDecode (
    .opcode     (irOp),
    .instrClass (clsRaw),
    .aluOp      (aluOpDec)
  );

  assign cls       = instr_class_t'(clsRaw);
  assign regMuxCls = (cls == CLS_ST) || (cls == CLS_CBZ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
      irOp  <= '0;
    end else begin
      state <= nextState;
      if (irLoadRaw) irOp <= opcode;
    end
  end

  always_comb begin
    nextState    = state;
    irLoadRaw    = 1'b0;
    w_pc         = 1'b0;
    reg_mux_sel  = 1'b0;
    w_regbank    = 1'b0;
    alu_mux_sel  = 1'b0;
    aluOp        = ALU_AND;
    jump_mux_sel = 1'b0;
    read_mem     = 1'b0;
    write_mem    = 1'b0;
    mem_sel      = 1'b0;
    illegal      = 1'b0;
    case (state)
      FETCH: begin
        if (run && imem_ready) begin
          irLoadRaw = 1'b1;
          nextState = DECODE;
        end
      end
      DECODE: begin
        reg_mux_sel = regMuxCls;
        nextState   = (cls == CLS_ILL) ? TRAP : EXEC;
      end
      EXEC: begin
        reg_mux_sel = regMuxCls;
        case (cls)
          CLS_R: begin
            aluOp     = aluOpDec;
            nextState = WB;
          end
          CLS_LD, CLS_ST: begin
            alu_mux_sel = 1'b1;
            aluOp       = aluOpDec;
            nextState   = MEM;
          end
          CLS_CBZ: begin
            aluOp        = aluOpDec;
            w_pc         = 1'b1;
            jump_mux_sel = zero;
            nextState    = FETCH;
          end
          CLS_B: begin
            w_pc         = 1'b1;
            jump_mux_sel = 1'b1;
            nextState    = FETCH;
          end
          default: nextState = TRAP;
        endcase
      end
      MEM: begin
        reg_mux_sel = regMuxCls;
        alu_mux_sel = 1'b1;
        aluOp       = aluOpDec;
        read_mem    = (cls == CLS_LD);
        write_mem   = (cls == CLS_ST);
        if (dmem_ready) begin
          // STUR retires here; LDUR still has to write back
          w_pc      = (cls == CLS_ST);
          nextState = (cls == CLS_ST) ? FETCH : WB;
        end
      end
      WB: begin
        reg_mux_sel = regMuxCls;
        alu_mux_sel = (cls == CLS_LD);
        aluOp       = aluOpDec;
        w_regbank   = 1'b1;
        mem_sel     = (cls == CLS_LD);
        w_pc        = 1'b1;
        nextState   = FETCH;
      end
      TRAP: illegal = 1'b1;
      default: nextState = FETCH;
    endcase
  end

  // State is already FETCH while reset is held; gating keeps ir_load low
  // too even if run/imem_ready are high during reset.
  assign ir_load = irLoadRaw & rst_n;
  assign op_alu  = OPW'(aluOp);

`ifdef CTRL_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt <= '0;
      ret_cnt <= '0;
    end else begin
      if (run)  cyc_cnt <= cyc_cnt + CNT_W'(1);
      if (w_pc) ret_cnt <= ret_cnt + CNT_W'(1);
    end
  end
`else
  // Counters not built.
`endif

endmodule
